// File: rtl/clk_mon_pkg.sv
// ============================================================================
//  Module      : clk_mon_pkg
//  Description : Shared types and helpers for the divided-clock ratio monitor.
//                Provides the monitor FSM state encoding and a tolerance
//                compare used for both period and high-time checks.
//  Contents    : mon_state_t  - 3-bit monitor state (IDLE/ARM/MEAS/LOCKED/LOST)
//                in_tol()     - |meas - expv| <= tol, evaluated unsigned-safe
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_mon_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      MEAS   = 3'd2,
      LOCKED = 3'd3,
      LOST   = 3'd4
   } mon_state_t;

   // Absolute difference is taken by ordering the operands first, so the
   // unsigned subtraction can never underflow.
   function automatic logic in_tol(input int unsigned meas,
                                   input int unsigned expv,
                                   input int unsigned tol);
      int unsigned diff;
      diff = (meas >= expv) ? (meas - expv) : (expv - meas);
      return (diff <= tol);
   endfunction

endpackage : clk_mon_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchronizer. Brings an asynchronous
//                level into the clk_in domain; both stages reset to 0.
//  Ports       : clk_in - destination clock
//                rstn   - asynchronous active-low reset
//                d_i    - asynchronous input level
//                q_o    - synchronized level (2 clk_in cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
   input  logic clk_in,
   input  logic rstn,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/clk_ratio_monitor.sv
// ============================================================================
//  Module      : clk_ratio_monitor
//  Description : Built-in self check for a clock divider. Samples clk_mon in
//                the clk_in domain, measures its period in clk_in cycles,
//                compares against EXP_RATIO +/- TOL and tracks lock.
//  Parameters  : EXP_RATIO  - expected period in clk_in cycles (>= 4)
//                TOL        - allowed |measured - EXP_RATIO|
//                LOCK_COUNT - consecutive matches needed to lock (1..15)
//                CNT_W      - counter width, must hold 2*EXP_RATIO+1
//  Ports       : clk_in     - reference clock
//                rstn       - asynchronous active-low reset
//                clk_mon    - monitored clock (asynchronous)
//                enable     - monitor enable
//                clr_err    - pulse, clears sticky error flag(s)
//                ratio_meas - last measured period
//                meas_valid - pulse, ratio_meas updated this cycle
//                locked     - high while in LOCKED
//                err        - sticky, lock lost by mismatch or timeout
//                state      - current mon_state_t
//                duty_err   - sticky high-time error (DUTY_CHECK_EN only)
//  Config      : define DUTY_CHECK_EN to add the high-time check and the
//                duty_err port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_ratio_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned EXP_RATIO  = 10,
   parameter int unsigned TOL        = 1,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk_in,
   input  logic             rstn,
   input  logic             clk_mon,
   input  logic             enable,
   input  logic             clr_err,
   output logic [CNT_W-1:0] ratio_meas,
   output logic             meas_valid,
   output logic             locked,
   output logic             err,
   output logic [2:0]       state
`ifdef DUTY_CHECK_EN
   ,
   output logic             duty_err
`endif
);

   localparam int unsigned c_ext_w   = CNT_W + 1;
   localparam logic [CNT_W:0] c_timeout = c_ext_w'(2 * EXP_RATIO);
   localparam logic [3:0]     c_lock    = 4'(LOCK_COUNT);

   // ------------------------------------------------------------------
   // Input path: 2-FF sync followed by an edge register. The detection
   // latency is fixed, so consecutive rises stay exactly one period apart.
   // ------------------------------------------------------------------
   logic mon_sync_w;
   logic mon_prev_q;
   logic rise_w;

   sync_2ff u_sync_mon (
      .clk_in (clk_in),
      .rstn   (rstn),
      .d_i    (clk_mon),
      .q_o    (mon_sync_w)
   );

   assign rise_w = mon_sync_w & ~mon_prev_q;

   // ------------------------------------------------------------------
   // Period counter. On a rise cycle cnt holds period-1, so cnt+1 is the
   // period. The +1 is taken one bit wider so a saturated counter never
   // wraps back into the tolerance window.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W:0]   cnt_inc_w;

   assign cnt_inc_w = {1'b0, cnt_q} + c_ext_w'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || rise_w) begin
         cnt_d = '0;
      end else if (!(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         mon_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         mon_prev_q <= mon_sync_w;
         cnt_q      <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Period qualification
   // ------------------------------------------------------------------
   mon_state_t state_q;
   logic       match_w;
   logic       timeout_w;
   logic       measuring_w;

   assign match_w     = in_tol(32'(cnt_inc_w), EXP_RATIO, TOL);
   assign timeout_w   = !rise_w && (cnt_inc_w == c_timeout);
   // ARM sees the first edge only, so there is no previous edge to measure from.
   assign measuring_w = enable && rise_w &&
                        ((state_q == MEAS) || (state_q == LOCKED) || (state_q == LOST));

   // ------------------------------------------------------------------
   // Monitor FSM with registered outputs
   // ------------------------------------------------------------------
   logic [3:0]       match_cnt_q;
   logic [3:0]       match_inc_w;
   logic [CNT_W-1:0] ratio_meas_q;
   logic             meas_valid_q;
   logic             locked_q;
   logic             err_q;

   assign match_inc_w = match_cnt_q + 4'd1;

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         match_cnt_q  <= '0;
         ratio_meas_q <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;

         // Cleared first; any error set later in this block takes priority.
         if (clr_err) begin
            err_q <= 1'b0;
         end

         if (measuring_w) begin
            ratio_meas_q <= cnt_inc_w[CNT_W] ? {CNT_W{1'b1}} : cnt_inc_w[CNT_W-1:0];
            meas_valid_q <= 1'b1;
         end

         if (!enable) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= ARM;
               end

               ARM: begin
                  if (rise_w) begin
                     state_q <= MEAS;
                  end
               end

               MEAS: begin
                  if (timeout_w) begin
                     state_q     <= ARM;
                     match_cnt_q <= '0;
                  end else if (rise_w) begin
                     if (match_w) begin
                        match_cnt_q <= match_inc_w;
                        if (match_inc_w >= c_lock) begin
                           state_q  <= LOCKED;
                           locked_q <= 1'b1;
                        end
                     end else begin
                        match_cnt_q <= '0;
                     end
                  end
               end

               LOCKED: begin
                  if (timeout_w) begin
                     state_q     <= ARM;
                     match_cnt_q <= '0;
                     locked_q    <= 1'b0;
                     err_q       <= 1'b1;
                  end else if (rise_w && !match_w) begin
                     state_q     <= LOST;
                     match_cnt_q <= '0;
                     locked_q    <= 1'b0;
                     err_q       <= 1'b1;
                  end
               end

               LOST: begin
                  if (timeout_w) begin
                     state_q     <= ARM;
                     match_cnt_q <= '0;
                  end else if (rise_w && match_w) begin
                     // This good period already counts toward relock.
                     state_q     <= MEAS;
                     match_cnt_q <= 4'd1;
                  end
               end

               default: begin
                  state_q     <= IDLE;
                  match_cnt_q <= '0;
                  locked_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ratio_meas = ratio_meas_q;
   assign meas_valid = meas_valid_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign state      = state_q;

`ifdef DUTY_CHECK_EN
   // ------------------------------------------------------------------
   // High-time check. The rise cycle itself is the first high cycle, so
   // on the next rise hcnt holds the high time of the period just ended.
   // Result is advisory only and never steers the FSM.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] hcnt_q;
   logic [CNT_W-1:0] hcnt_d;
   logic             duty_fail_w;
   logic             duty_err_q;

   always_comb begin
      hcnt_d = hcnt_q;
      if (!enable) begin
         hcnt_d = '0;
      end else if (rise_w) begin
         hcnt_d = CNT_W'(1);
      end else if (mon_sync_w && !(&hcnt_q)) begin
         hcnt_d = hcnt_q + CNT_W'(1);
      end
   end

   assign duty_fail_w = measuring_w && !in_tol(32'(hcnt_q), EXP_RATIO / 2, TOL);

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         hcnt_q     <= '0;
         duty_err_q <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         if (clr_err) begin
            duty_err_q <= 1'b0;
         end
         if (duty_fail_w) begin
            duty_err_q <= 1'b1;
         end
      end
   end

   assign duty_err = duty_err_q;
`endif

endmodule : clk_ratio_monitor

`default_nettype wire

// File: tb/tb_clk_ratio_monitor.sv
// ============================================================================
//  Module      : tb_clk_ratio_monitor
//  Description : Self-checking bench for clk_ratio_monitor. A clk_mon
//                generator pushes the true period of every edge pair into a
//                scoreboard; each meas_valid pops and compares ratio_meas.
//                Directed checks cover lock, tolerance, loss, timeout,
//                clr_err, reset and enable behaviour (and duty check when
//                DUTY_CHECK_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_ratio_monitor;

   localparam int unsigned CNT_W = 8;
   localparam int S_IDLE = 0, S_ARM = 1, S_MEAS = 2, S_LOCKED = 3, S_LOST = 4;

   logic             clk_in  = 1'b0;
   logic             rstn    = 1'b1;
   logic             clk_mon;
   logic             enable  = 1'b0;
   logic             clr_err = 1'b0;
   logic [CNT_W-1:0] ratio_meas;
   logic             meas_valid;
   logic             locked;
   logic             err;
   logic [2:0]       state;
`ifdef DUTY_CHECK_EN
   logic             duty_err;
`endif

   int n_vec  = 0;
   int n_miss = 0;
   int sb_q[$];

   int mon_period = 10;
   int mon_high   = 5;
   bit mon_run    = 1'b0;

   always #5 clk_in = ~clk_in;

   clk_ratio_monitor #(
      .EXP_RATIO  (10),
      .TOL        (1),
      .LOCK_COUNT (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_in     (clk_in),
      .rstn       (rstn),
      .clk_mon    (clk_mon),
      .enable     (enable),
      .clr_err    (clr_err),
      .ratio_meas (ratio_meas),
      .meas_valid (meas_valid),
      .locked     (locked),
      .err        (err),
      .state      (state)
`ifdef DUTY_CHECK_EN
      ,
      .duty_err   (duty_err)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp_v);
      n_vec++;
      if (got != exp_v) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
      end
   endtask

   // Advance to the next falling edge and service the scoreboard.
   task automatic tick();
      @(negedge clk_in);
      if (meas_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_nonempty", sb_q.size(), 1);
         end else begin
            chk("ratio_meas", int'(ratio_meas), sb_q.pop_front());
         end
      end
   endtask

   // Returns on the falling edge where the n-th meas_valid is seen.
   task automatic wait_meas(input int n, input string tag);
      int got = 0;
      for (int i = 0; i < 100 * n && got < n; i++) begin
         tick();
         if (meas_valid) got++;
      end
      if (got < n) chk({tag, "_timeout"}, got, n);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      tick();
   endtask

   // clk_mon generator, edge-aligned just after clk_in falls. Records the
   // exact period between consecutive rises it drives.
   initial begin
      int  phase = 0;
      int  since = 0;
      bit  have_prev = 1'b0;
      clk_mon = 1'b0;
      forever begin
         @(negedge clk_in);
         #1;
         if (!mon_run) begin
            clk_mon   = 1'b0;
            phase     = 0;
            have_prev = 1'b0;
            continue;
         end
         if (phase == 0) begin
            clk_mon = 1'b1;
            if (have_prev) sb_q.push_back(since);
            since     = 0;
            have_prev = 1'b1;
         end else if (phase == mon_high) begin
            clk_mon = 1'b0;
         end
         since++;
         phase = (phase + 1 >= mon_period) ? 0 : phase + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      // ---------------- reset state ----------------
      #2 rstn = 1'b0;
      repeat (3) tick();
      chk("rst_state",      int'(state),      S_IDLE);
      chk("rst_ratio_meas", int'(ratio_meas), 0);
      chk("rst_meas_valid", int'(meas_valid), 0);
      chk("rst_locked",     int'(locked),     0);
      chk("rst_err",        int'(err),        0);
`ifdef DUTY_CHECK_EN
      chk("rst_duty_err",   int'(duty_err),   0);
`endif
      rstn = 1'b1;
      tick();
      enable = 1'b1;
      repeat (2) tick();
      chk("arm_state", int'(state), S_ARM);

      // ---------------- /10 lock ----------------
      mon_run = 1'b1;
      wait_meas(1, "lock_m1");
      chk("lock_m1_state",  int'(state),  S_MEAS);
      chk("lock_m1_locked", int'(locked), 0);
      wait_meas(2, "lock_m3");
      chk("lock_m3_locked", int'(locked), 0);
      wait_meas(1, "lock_m4");
      chk("lock_m4_locked", int'(locked), 1);
      chk("lock_m4_state",  int'(state),  S_LOCKED);
      chk("lock_m4_err",    int'(err),    0);

      // ---------------- /11 within tolerance ----------------
      mon_period = 11;
      wait_meas(2, "tol11");
      chk("tol11_state",  int'(state),  S_LOCKED);
      chk("tol11_locked", int'(locked), 1);
      chk("tol11_err",    int'(err),    0);
      mon_period = 10;
      wait_meas(1, "back10");

      // ---------------- /12 loss of lock ----------------
      mon_period = 12;
      wait_meas(1, "lost12");
      chk("lost12_state",  int'(state),  S_LOST);
      chk("lost12_locked", int'(locked), 0);
      chk("lost12_err",    int'(err),    1);
      wait_meas(1, "lost12b");
      chk("lost12b_state", int'(state),  S_LOST);
      mon_period = 10;
      wait_meas(1, "relost");
      chk("relost_state",  int'(state),  S_MEAS);
      wait_meas(3, "relock");
      chk("relock_state",  int'(state),  S_LOCKED);
      chk("relock_locked", int'(locked), 1);
      chk("relock_err_sticky", int'(err), 1);
      pulse_clr();
      chk("clr_err_1", int'(err), 0);

      // ---------------- timeout while locked ----------------
      wait_meas(1, "pre_to");
      mon_run = 1'b0;
      repeat (19) tick();
      chk("to_before_state", int'(state), S_LOCKED);
      tick();
      chk("to_state",  int'(state),  S_ARM);
      chk("to_err",    int'(err),    1);
      chk("to_locked", int'(locked), 0);
      pulse_clr();
      chk("clr_err_2", int'(err), 0);
      mon_run = 1'b1;
      wait_meas(3, "to_relock3");
      chk("to_relock3_locked", int'(locked), 0);
      wait_meas(1, "to_relock4");
      chk("to_relock4_locked", int'(locked), 1);

      // ---------------- reset while locked ----------------
      wait_meas(1, "pre_rst");
      rstn    = 1'b0;
      mon_run = 1'b0;
      sb_q.delete();
      #1;
      chk("mrst_state",      int'(state),      S_IDLE);
      chk("mrst_ratio_meas", int'(ratio_meas), 0);
      chk("mrst_meas_valid", int'(meas_valid), 0);
      chk("mrst_locked",     int'(locked),     0);
      chk("mrst_err",        int'(err),        0);
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      mon_run = 1'b1;
      wait_meas(3, "rst_relock3");
      chk("rst_relock3_locked", int'(locked), 0);
      wait_meas(1, "rst_relock4");
      chk("rst_relock4_locked", int'(locked), 1);

      // ---------------- disable ----------------
      mon_run = 1'b0;
      repeat (10) tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("dis_state",      int'(state),      S_IDLE);
      chk("dis_locked",     int'(locked),     0);
      chk("dis_ratio_held", int'(ratio_meas), 10);

`ifdef DUTY_CHECK_EN
      // ---------------- duty cycle ----------------
      chk("duty_pre", int'(duty_err), 0);
      enable = 1'b1;
      repeat (2) tick();
      mon_high = 3;
      mon_run  = 1'b1;
      wait_meas(2, "duty37");
      chk("duty37_err", int'(duty_err), 1);
      mon_high = 5;
      wait_meas(2, "duty55a");
      pulse_clr();
      wait_meas(3, "duty55b");
      chk("duty55_err", int'(duty_err), 0);
      mon_run = 1'b0;
      repeat (10) tick();
`endif

      chk("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_clk_ratio_monitor

`default_nettype wire
